// File: rtl/mips_storage_unit.sv
// Register file (32x32, r0 hardwired to zero) plus word-organised data memory for the MIPS core.
// Optional build macro STORAGE_RF_BYPASS_EN: write-through forwarding on both register read ports.
module mips_storage_unit #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned MEM_AW    = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rf_write,
  input  logic [4:0]  rf_wr,
  input  logic [31:0] rf_wd,
  input  logic [4:0]  rf_rr1,
  input  logic [4:0]  rf_rr2,
  output logic [31:0] rf_rd1,
  output logic [31:0] rf_rd2,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);

  logic [31:0]       regs [32];
  logic [31:0]       mem  [MEM_WORDS];
  logic [MEM_AW-1:0] mem_idx;
  logic              rf_we;
  logic              mem_we;

  // Only a definite 1 on an enable may change state.
  assign rf_we  = (rf_write === 1'b1);
  assign mem_we = (mem_write === 1'b1);

  // Byte offset and bits above the memory size are don't-care; addresses wrap.
  assign mem_idx = mem_address[MEM_AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:MEM_AW+2], mem_address[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (rf_we && (rf_wr != 5'd0)) begin
      regs[rf_wr] <= rf_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_write_data;
    end
  end

`ifdef STORAGE_RF_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = rf_we && (rf_wr != 5'd0) && !reset;

  always_comb begin
    rf_rd1 = (rf_rr1 == 5'd0) ? 32'h0 : regs[rf_rr1];
    rf_rd2 = (rf_rr2 == 5'd0) ? 32'h0 : regs[rf_rr2];
    if (fwd_ok && (rf_rr1 == rf_wr)) rf_rd1 = rf_wd;
    if (fwd_ok && (rf_rr2 == rf_wr)) rf_rd2 = rf_wd;
  end
`else
  always_comb begin
    rf_rd1 = (rf_rr1 == 5'd0) ? 32'h0 : regs[rf_rr1];
    rf_rd2 = (rf_rr2 == 5'd0) ? 32'h0 : regs[rf_rr2];
  end
`endif

  assign mem_read_data = mem[mem_idx];

endmodule

// File: tb/tb_mips_storage_unit.sv
// Self-checking bench for mips_storage_unit: directed cases plus randomized traffic vs a model.
module tb_mips_storage_unit;

  logic        clk = 1'b0;
  logic        reset, rf_write, mem_write;
  logic [4:0]  rf_wr, rf_rr1, rf_rr2;
  logic [31:0] rf_wd, mem_address, mem_write_data;
  logic [31:0] rf_rd1, rf_rd2, mem_read_data;

  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [1024];
  int          checks = 0;
  int          failures = 0;

  mips_storage_unit #(.MEM_WORDS(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .rf_write       (rf_write),
    .rf_wr          (rf_wr),
    .rf_wd          (rf_wd),
    .rf_rr1         (rf_rr1),
    .rf_rr2         (rf_rr2),
    .rf_rd1         (rf_rd1),
    .rf_rd2         (rf_rd2),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rr);
    if (rr == 5'd0) return 32'h0;
`ifdef STORAGE_RF_BYPASS_EN
    if (rf_write === 1'b1 && rf_wr != 5'd0 && reset === 1'b0 && rr == rf_wr) return rf_wd;
`endif
    return m_regs[rr];
  endfunction

  // Word index of a byte address in a 1024-word memory.
  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic check_reads(input string tag);
    #1;
    check({tag, "_rd1"}, rf_rd1, exp_rd(rf_rr1));
    check({tag, "_rd2"}, rf_rd2, exp_rd(rf_rr2));
    check({tag, "_mem"}, mem_read_data, m_mem[widx(mem_address)]);
  endtask

  // One rising edge; model commits from the inputs held across it.
  task automatic tick();
    @(posedge clk);
    if (reset === 1'b1) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (rf_write === 1'b1 && rf_wr != 5'd0) begin
      m_regs[rf_wr] = rf_wd;
    end
    if (mem_write === 1'b1) m_mem[widx(mem_address)] = mem_write_data;
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; rf_write = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    idle();
    rf_wr = '0; rf_wd = '0; rf_rr1 = '0; rf_rr2 = '0;
    mem_address = '0; mem_write_data = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    idle();
    // Memory starts undefined; fill it by stores so the model is exact.
    mem_write = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      mem_address = 32'(i) << 2;
      mem_write_data = $urandom;
      tick();
    end
    idle();

    // Reset clears registers and beats a coincident write.
    rf_write = 1'b1; rf_wr = 5'd5; rf_wd = 32'hDEADBEEF;
    tick();
    idle(); rf_rr1 = 5'd5; #1 check("x5_written", rf_rd1, 32'hDEADBEEF);
    reset = 1'b1; rf_write = 1'b1; rf_wr = 5'd5; rf_wd = 32'h0BADF00D;
    tick();
    idle();
    rf_rr1 = 5'd5; #1 check("x5_after_reset", rf_rd1, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rf_rr1 = 5'(i); rf_rr2 = 5'(31 - i);
      #1;
      check("reset_all_rd1", rf_rd1, 32'h0);
      check("reset_all_rd2", rf_rd2, 32'h0);
    end

    // r0 hardwiring.
    rf_write = 1'b1; rf_wr = 5'd0; rf_wd = 32'h12345678;
    tick();
    idle(); rf_rr1 = 5'd0; rf_rr2 = 5'd0;
    #1 check("r0_rd1", rf_rd1, 32'h0);
    check("r0_rd2", rf_rd2, 32'h0);

    // Write timing: pre-edge read is old value (or rf_wd with forwarding).
    rf_write = 1'b1; rf_wr = 5'd8; rf_wd = 32'hA5A5A5A5; rf_rr1 = 5'd8; rf_rr2 = 5'd8;
    check_reads("x8_pre_edge");
    tick();
    rf_wr = 5'd9; rf_wd = 32'h0000FFFF;
    tick();
    idle(); rf_rr1 = 5'd8; rf_rr2 = 5'd9;
    #1 check("x8_read", rf_rd1, 32'hA5A5A5A5);
    check("x9_read", rf_rd2, 32'h0000FFFF);

    // Store/load with ignored byte offset.
    mem_write = 1'b1; mem_address = 32'h40; mem_write_data = 32'hCAFEF00D;
    tick();
    idle();
    mem_address = 32'h40; #1 check("load_40", mem_read_data, 32'hCAFEF00D);
    mem_address = 32'h41; #1 check("load_41", mem_read_data, 32'hCAFEF00D);
    mem_address = 32'h43; #1 check("load_43", mem_read_data, 32'hCAFEF00D);
    mem_address = 32'h44; #1 check("load_44", mem_read_data, m_mem[17]);

    // Wrap-around modulo 4*MEM_WORDS.
    mem_write = 1'b1; mem_address = 32'h1000; mem_write_data = 32'h11111111;
    tick();
    idle(); mem_address = 32'h0;
    #1 check("wrap_load_0", mem_read_data, 32'h11111111);

    // Concurrent register and memory writes.
    rf_write = 1'b1; rf_wr = 5'd3; rf_wd = 32'd7;
    mem_write = 1'b1; mem_address = 32'h8; mem_write_data = 32'd9;
    tick();
    idle(); rf_rr1 = 5'd3; mem_address = 32'h8;
    #1 check("conc_x3", rf_rd1, 32'd7);
    check("conc_mem8", mem_read_data, 32'd9);

    // mem_write low: changing address/data must not store.
    for (int i = 0; i < 8; i++) begin
      mem_address = $urandom; mem_write_data = $urandom;
      tick();
    end
    mem_address = 32'h8; #1 check("gated_mem8", mem_read_data, 32'd9);
    mem_address = 32'h40; #1 check("gated_mem40", mem_read_data, 32'hCAFEF00D);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 31) == 0);
      rf_write       = 1'($urandom_range(0, 1));
      rf_wr          = 5'($urandom);
      rf_wd          = $urandom;
      rf_rr1         = ($urandom_range(0, 3) == 0) ? rf_wr : 5'($urandom);
      rf_rr2         = ($urandom_range(0, 3) == 0) ? rf_wr : 5'($urandom);
      mem_write      = 1'($urandom_range(0, 1));
      mem_address    = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
      mem_write_data = $urandom;
      check_reads("rand");
      tick();
    end
    idle();
    check_reads("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
